mem_access_ctrl: RTL and testbench

- Data-memory access stage directly upstream of the writeback/store-lane mux.
- Accepts one lane-aligned memory op (address, store data, strobe) per handshake and checks address alignment (AdEL/AdES), suppressing the bus access on a fault.
- Drives a valid/ready data-memory bus and waits for load data.
- Hands the raw read word plus `ea` (`addr[1:0]`) to the writeback mux, which does byte/half extraction and lwl/lwr merge.

---
 rtl/mem_access_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Data-memory access stage. It checks address alignment and drives
//            a valid/ready data bus. The raw read word and byte offset go to
//            the writeback mux.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
   parameter int         ADDR_W   = 32,
   parameter logic [4:0] EXC_ADEL = 5'd4,
   parameter logic [4:0] EXC_ADES = 5'd5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   input  logic [3:0]        in_strb,
   input  logic              in_is_load,
   input  logic              in_is_store,
   input  logic [1:0]        in_size,
   input  logic [31:0]       in_pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_strb,
   output logic              mem_read,
   output logic              mem_write,
   input  logic              mem_req_ready,
   input  logic              mem_rdata_valid,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_rdata,
   output logic [1:0]        out_ea,
   output logic [31:0]       out_pc,
   output logic              out_exc,
   output logic [4:0]        out_exc_code,
   output logic [ADDR_W-1:0] out_badvaddr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [31:0]       wdata_q,    wdata_d;
   logic [3:0]        strb_q,     strb_d;
   logic              is_load_q,  is_load_d;
   logic              is_store_q, is_store_d;
   logic [31:0]       pc_q,       pc_d;
   logic [31:0]       rdata_q,    rdata_d;
   logic              exc_q,      exc_d;
   logic [4:0]        exc_code_q, exc_code_d;
   logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

   logic accept;
   logic misaligned;
   logic new_load;
   logic new_store;

   assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept     = in_valid & in_ready;
   // A load+store combination is illegal; store wins so the bus sees one op.
   assign new_store  = in_is_store;
   assign new_load   = in_is_load & ~in_is_store;
   assign misaligned = ((in_size == 2'd1) & in_addr[0]) |
                       ((in_size == 2'd2) & (in_addr[1:0] != 2'b00));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      is_load_d  = is_load_q;
      is_store_d = is_store_q;
      pc_d       = pc_q;
      rdata_d    = rdata_q;
      exc_d      = exc_q;
      exc_code_d = exc_code_q;
      badvaddr_d = badvaddr_q;

      case (state_q)
         S_REQ: begin
            if (mem_req_ready) begin
               state_d = is_store_q ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rdata_valid) begin
               rdata_d = mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      // Accept only happens from IDLE or a retiring DONE, so it overrides the above.
      if (accept) begin
         addr_d     = in_addr;
         wdata_d    = in_wdata;
         strb_d     = in_strb;
         is_load_d  = new_load;
         is_store_d = new_store;
         pc_d       = in_pc;
         rdata_d    = 32'd0;
         exc_d      = misaligned;
         exc_code_d = misaligned ? (new_store ? EXC_ADES : EXC_ADEL) : 5'd0;
         badvaddr_d = misaligned ? in_addr : '0;
         if (misaligned) begin
            state_d = S_DONE;
         end else if (new_load | new_store) begin
            state_d = S_REQ;
         end else begin
            state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         strb_q     <= 4'd0;
         is_load_q  <= 1'b0;
         is_store_q <= 1'b0;
         pc_q       <= 32'd0;
         rdata_q    <= 32'd0;
         exc_q      <= 1'b0;
         exc_code_q <= 5'd0;
         badvaddr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         is_load_q  <= is_load_d;
         is_store_q <= is_store_d;
         pc_q       <= pc_d;
         rdata_q    <= rdata_d;
         exc_q      <= exc_d;
         exc_code_q <= exc_code_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   // Bus outputs come only from held capture registers, so they stay stable across a stall.
   assign mem_read     = (state_q == S_REQ) & is_load_q;
   assign mem_write    = (state_q == S_REQ) & is_store_q;
   assign mem_addr     = (state_q == S_REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wdata    = mem_write ? wdata_q : 32'd0;
   assign mem_strb     = mem_write ? strb_q : 4'd0;

   assign out_valid    = (state_q == S_DONE);
   assign out_rdata    = rdata_q;
   assign out_ea       = addr_q[1:0];
   assign out_pc       = pc_q;
   assign out_exc      = exc_q;
   assign out_exc_code = exc_code_q;
   assign out_badvaddr = badvaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// Testbench for mem_access_ctrl: directed vector table, reset corner cases and
// randomized ops scored against a rule-level reference model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [3:0]  in_strb;
   logic        in_is_load;
   logic        in_is_store;
   logic [1:0]  in_size;
   logic [31:0] in_pc;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_strb;
   logic        mem_read;
   logic        mem_write;
   logic        mem_req_ready;
   logic        mem_rdata_valid;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic [1:0]  out_ea;
   logic [31:0] out_pc;
   logic        out_exc;
   logic [4:0]  out_exc_code;
   logic [31:0] out_badvaddr;

   always #5 clk = ~clk;

   mem_access_ctrl #(
      .ADDR_W   (32),
      .EXC_ADEL (5'd4),
      .EXC_ADES (5'd5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_addr         (in_addr),
      .in_wdata        (in_wdata),
      .in_strb         (in_strb),
      .in_is_load      (in_is_load),
      .in_is_store     (in_is_store),
      .in_size         (in_size),
      .in_pc           (in_pc),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_strb        (mem_strb),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_req_ready   (mem_req_ready),
      .mem_rdata_valid (mem_rdata_valid),
      .mem_rdata       (mem_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_rdata       (out_rdata),
      .out_ea          (out_ea),
      .out_pc          (out_pc),
      .out_exc         (out_exc),
      .out_exc_code    (out_exc_code),
      .out_badvaddr    (out_badvaddr)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        ld;
      logic        st;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] pc;
      logic [31:0] rdata;
      int          stall;
      int          dly;
      int          hold;
   } op_t;

   typedef struct {
      logic        exc;
      logic [4:0]  code;
      logic [31:0] bad;
      logic        rd;
      logic        wr;
      logic [31:0] maddr;
      logic [3:0]  mstrb;
      int          lat;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      op_t  op;
      exp_t e;
   } vec_t;

   typedef struct {
      logic        ready_at_present;
      int          lat;
      logic        valid;
      logic [31:0] rdata;
      logic [1:0]  ea;
      logic [31:0] pc;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] bad;
      logic        bus_seen;
      logic        rd;
      logic        wr;
      logic [31:0] maddr;
      logic [3:0]  mstrb;
      logic [31:0] mwdata;
      int          bus_cycles;
      logic        both;
      logic        bus_unstable;
      logic        out_unstable;
      logic        leak;
   } res_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic op_t mk_op(input logic ld, input logic st, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [31:0] pc,
                                 input logic [31:0] rdata, input int stall, input int dly,
                                 input int hold);
      op_t o;
      o.ld = ld; o.st = st; o.size = size; o.addr = addr; o.wdata = wdata;
      o.strb = strb; o.pc = pc; o.rdata = rdata; o.stall = stall; o.dly = dly;
      o.hold = hold;
      return o;
   endfunction

   function automatic exp_t mk_exp(input logic exc, input logic [4:0] code,
                                   input logic [31:0] bad, input logic rd, input logic wr,
                                   input logic [31:0] maddr, input logic [3:0] mstrb,
                                   input int lat, input logic [31:0] rdata);
      exp_t e;
      e.exc = exc; e.code = code; e.bad = bad; e.rd = rd; e.wr = wr;
      e.maddr = maddr; e.mstrb = mstrb; e.lat = lat; e.rdata = rdata;
      return e;
   endfunction

   // Reference: outcome of one op from the access rules and the bus timing it sees.
   function automatic exp_t model(input op_t op);
      exp_t e;
      bit   store, load, fault;
      store = op.st;
      load  = op.ld && !op.st;
      case (op.size)
         2'd1:    fault = (op.addr % 2) != 0;
         2'd2:    fault = (op.addr % 4) != 0;
         default: fault = 0;
      endcase
      e.exc   = fault;
      e.code  = fault ? (store ? 5'd5 : 5'd4) : 5'd0;
      e.bad   = fault ? op.addr : 32'd0;
      e.rd    = !fault && load;
      e.wr    = !fault && store;
      e.maddr = op.addr - (op.addr % 4);
      e.mstrb = e.wr ? op.strb : 4'd0;
      if (e.wr)      e.lat = 2 + op.stall;
      else if (e.rd) e.lat = 2 + op.stall + op.dly;
      else           e.lat = 1;
      e.rdata = e.rd ? op.rdata : 32'd0;
      return e;
   endfunction

   task automatic run_op(input op_t op, output res_t r);
      int cyc;
      int since;
      bit req_done;
      r.ready_at_present = 0; r.lat = 0; r.valid = 0; r.rdata = 0; r.ea = 0; r.pc = 0;
      r.exc = 0; r.code = 0; r.bad = 0; r.bus_seen = 0; r.rd = 0; r.wr = 0;
      r.maddr = 0; r.mstrb = 0; r.mwdata = 0; r.bus_cycles = 0; r.both = 0;
      r.bus_unstable = 0; r.out_unstable = 0; r.leak = 0;

      in_valid = 1; in_addr = op.addr; in_wdata = op.wdata; in_strb = op.strb;
      in_is_load = op.ld; in_is_store = op.st; in_size = op.size; in_pc = op.pc;
      out_ready = 1; mem_req_ready = 0; mem_rdata_valid = 0;
      #1;
      r.ready_at_present = in_ready;
      @(posedge clk); #1;
      in_valid = 0; in_is_load = 0; in_is_store = 0; out_ready = 0;
      in_addr = $urandom; in_wdata = $urandom; in_pc = $urandom;

      cyc = 1; since = 0; req_done = 0;
      while (!out_valid && cyc < 40) begin
         if (mem_read || mem_write) begin
            if (!r.bus_seen) begin
               r.bus_seen = 1; r.rd = mem_read; r.wr = mem_write; r.maddr = mem_addr;
               r.mstrb = mem_strb; r.mwdata = mem_wdata;
            end else if ({mem_read, mem_write, mem_addr, mem_strb, mem_wdata} !=
                         {r.rd, r.wr, r.maddr, r.mstrb, r.mwdata}) begin
               r.bus_unstable = 1;
            end
            if (mem_read && mem_write) r.both = 1;
            r.bus_cycles++;
            mem_req_ready   = (r.bus_cycles > op.stall);
            // Junk read data during the request phase must be ignored.
            mem_rdata_valid = 1;
            mem_rdata       = 32'hBAD0_BAD0;
            if (mem_req_ready) req_done = 1;
         end else begin
            mem_req_ready = 0;
            mem_rdata     = $urandom;
            if (req_done) begin
               since++;
               mem_rdata_valid = (since == op.dly);
               if (since == op.dly) mem_rdata = op.rdata;
            end else begin
               mem_rdata_valid = 0;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      mem_req_ready = 0; mem_rdata_valid = 0;
      r.lat = cyc; r.valid = out_valid; r.rdata = out_rdata; r.ea = out_ea; r.pc = out_pc;
      r.exc = out_exc; r.code = out_exc_code; r.bad = out_badvaddr;

      for (int h = 0; h < op.hold; h++) begin
         in_valid = 1; in_is_load = 1; in_size = 2'd2; in_addr = 32'h0000_9000;
         #1;
         if (in_ready) r.leak = 1;
         @(posedge clk); #1;
         if (!out_valid || out_rdata !== r.rdata || out_ea !== r.ea || out_pc !== r.pc ||
             out_exc !== r.exc || out_exc_code !== r.code || out_badvaddr !== r.bad)
            r.out_unstable = 1;
         if (mem_read || mem_write) r.leak = 1;
      end
      in_valid = 0; in_is_load = 0;
   endtask

   task automatic compare(input string tag, input op_t op, input exp_t e, input res_t r);
      chk($sformatf("%s.in_ready", tag), r.ready_at_present, 1);
      chk($sformatf("%s.latency", tag), r.lat, e.lat);
      chk($sformatf("%s.out_valid", tag), r.valid, 1);
      chk($sformatf("%s.out_exc", tag), r.exc, e.exc);
      chk($sformatf("%s.exc_code", tag), r.code, e.code);
      chk($sformatf("%s.badvaddr", tag), r.bad, e.bad);
      chk($sformatf("%s.out_rdata", tag), r.rdata, e.rdata);
      chk($sformatf("%s.out_ea", tag), r.ea, op.addr[1:0]);
      chk($sformatf("%s.out_pc", tag), r.pc, op.pc);
      chk($sformatf("%s.mem_read", tag), r.rd, e.rd);
      chk($sformatf("%s.mem_write", tag), r.wr, e.wr);
      chk($sformatf("%s.bus_cycles", tag), r.bus_cycles, (e.rd || e.wr) ? op.stall + 1 : 0);
      if (e.rd || e.wr) begin
         chk($sformatf("%s.mem_addr", tag), r.maddr, e.maddr);
         chk($sformatf("%s.mem_strb", tag), r.mstrb, e.mstrb);
      end
      if (e.wr) chk($sformatf("%s.mem_wdata", tag), r.mwdata, op.wdata);
      chk($sformatf("%s.rd_and_wr", tag), r.both, 0);
      chk($sformatf("%s.bus_stable", tag), r.bus_unstable, 0);
      chk($sformatf("%s.out_stable", tag), r.out_unstable, 0);
      chk($sformatf("%s.no_accept_in_hold", tag), r.leak, 0);
   endtask

   task automatic drain();
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("drain.out_valid", out_valid, 0);
   endtask

   task automatic reset_mid(input bit in_wait);
      string tag;
      tag = in_wait ? "rst_wait" : "rst_req";
      drain();
      in_valid = 1; in_addr = 32'h0000_1008; in_is_load = 1; in_is_store = 0;
      in_size = 2'd2; in_pc = 32'h0040_0100; in_wdata = 0; in_strb = 0;
      @(posedge clk); #1;
      in_valid = 0; in_is_load = 0;
      chk($sformatf("%s.req_read", tag), mem_read, 1);
      if (in_wait) begin
         mem_req_ready = 1;
         @(posedge clk); #1;
         mem_req_ready = 0;
         chk($sformatf("%s.wait_read", tag), mem_read, 0);
         chk($sformatf("%s.wait_valid", tag), out_valid, 0);
      end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk($sformatf("%s.mem_read", tag), mem_read, 0);
      chk($sformatf("%s.mem_write", tag), mem_write, 0);
      chk($sformatf("%s.out_valid", tag), out_valid, 0);
      chk($sformatf("%s.in_ready", tag), in_ready, 1);
      chk($sformatf("%s.out_rdata", tag), out_rdata, 0);
      chk($sformatf("%s.out_pc", tag), out_pc, 0);
      chk($sformatf("%s.out_exc", tag), out_exc, 0);
      chk($sformatf("%s.badvaddr", tag), out_badvaddr, 0);
      chk($sformatf("%s.mem_addr", tag), mem_addr, 0);
      mem_rdata_valid = 1; mem_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mem_rdata_valid = 0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s.late_data_valid%0d", tag, k), out_valid, 0);
         chk($sformatf("%s.late_data_rdata%0d", tag, k), out_rdata, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      op_t  op;
      exp_t e;
      res_t r;

      tbl[0].op = mk_op(1, 0, 2'd2, 32'h0000_1002, 0, 4'h0, 32'h0040_0000, 32'h1111_1111, 0, 1, 0);
      tbl[0].e  = mk_exp(1, 5'd4, 32'h0000_1002, 0, 0, 0, 0, 1, 0);
      tbl[1].op = mk_op(0, 1, 2'd1, 32'h0000_2001, 32'h0000_BEEF, 4'h3, 32'h0040_0004, 0, 0, 1, 1);
      tbl[1].e  = mk_exp(1, 5'd5, 32'h0000_2001, 0, 0, 0, 0, 1, 0);
      tbl[2].op = mk_op(1, 0, 2'd2, 32'h0000_1004, 0, 4'h0, 32'h0040_0008, 32'hDEAD_BEEF, 3, 2, 2);
      tbl[2].e  = mk_exp(0, 0, 0, 1, 0, 32'h0000_1004, 4'h0, 7, 32'hDEAD_BEEF);
      tbl[3].op = mk_op(0, 1, 2'd0, 32'h0000_2003, 32'hAB00_0000, 4'b1000, 32'h0040_000C, 0, 0, 1, 0);
      tbl[3].e  = mk_exp(0, 0, 0, 0, 1, 32'h0000_2000, 4'b1000, 2, 0);
      tbl[4].op = mk_op(0, 1, 2'd3, 32'h0000_3001, 32'h0012_3456, 4'b0111, 32'h0040_0010, 0, 0, 1, 2);
      tbl[4].e  = mk_exp(0, 0, 0, 0, 1, 32'h0000_3000, 4'b0111, 2, 0);
      tbl[5].op = mk_op(1, 0, 2'd0, 32'h0000_3002, 0, 4'h0, 32'h0040_0014, 32'h1122_3344, 0, 1, 0);
      tbl[5].e  = mk_exp(0, 0, 0, 1, 0, 32'h0000_3000, 4'h0, 3, 32'h1122_3344);
      tbl[6].op = mk_op(0, 0, 2'd0, 32'h0000_5003, 32'hFFFF_FFFF, 4'hF, 32'h0040_0018, 0, 0, 1, 1);
      tbl[6].e  = mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tbl[7].op = mk_op(1, 1, 2'd2, 32'h0000_6004, 32'h5555_AAAA, 4'hF, 32'h0040_001C, 0, 0, 1, 0);
      tbl[7].e  = mk_exp(0, 0, 0, 0, 1, 32'h0000_6004, 4'hF, 2, 0);
      tbl[8].op = mk_op(1, 1, 2'd1, 32'h0000_6001, 32'h0000_1234, 4'h3, 32'h0040_0020, 0, 0, 1, 0);
      tbl[8].e  = mk_exp(1, 5'd5, 32'h0000_6001, 0, 0, 0, 0, 1, 0);
      tbl[9].op = mk_op(1, 0, 2'd1, 32'h0000_7002, 0, 4'h0, 32'h0040_0024, 32'h0000_8001, 1, 3, 0);
      tbl[9].e  = mk_exp(0, 0, 0, 1, 0, 32'h0000_7000, 4'h0, 6, 32'h0000_8001);

      rst = 1; in_valid = 0; in_addr = 0; in_wdata = 0; in_strb = 0; in_is_load = 0;
      in_is_store = 0; in_size = 0; in_pc = 0; mem_req_ready = 0; mem_rdata_valid = 0;
      mem_rdata = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.out_valid", out_valid, 0);
      chk("reset.in_ready", in_ready, 1);
      chk("reset.mem_read", mem_read, 0);
      chk("reset.mem_write", mem_write, 0);
      chk("reset.out_rdata", out_rdata, 0);
      chk("reset.out_pc", out_pc, 0);
      chk("reset.out_ea", out_ea, 0);
      chk("reset.out_exc", out_exc, 0);
      chk("reset.exc_code", out_exc_code, 0);
      chk("reset.badvaddr", out_badvaddr, 0);
      rst = 0;
      @(posedge clk); #1;

      // Consecutive entries are presented while the previous one sits in DONE.
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, r);
         compare($sformatf("vec%0d", i), tbl[i].op, tbl[i].e, r);
      end

      reset_mid(1'b1);
      op = mk_op(1, 0, 2'd2, 32'h0000_1010, 0, 4'h0, 32'h0040_0200, 32'h0BAD_F00D, 0, 1, 0);
      run_op(op, r);
      compare("after_rst_wait", op, model(op), r);

      reset_mid(1'b0);
      op = mk_op(1, 0, 2'd2, 32'h0000_1014, 0, 4'h0, 32'h0040_0204, 32'h7777_0001, 1, 2, 1);
      run_op(op, r);
      compare("after_rst_req", op, model(op), r);

      for (int i = 0; i < 150; i++) begin
         op.ld    = 1'($urandom_range(0, 1));
         op.st    = 1'($urandom_range(0, 1));
         op.size  = 2'($urandom_range(0, 3));
         if (!op.ld && !op.st) op.size = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
         op.addr  = $urandom;
         op.wdata = $urandom;
         op.strb  = 4'($urandom_range(0, 15));
         op.pc    = $urandom;
         op.rdata = $urandom;
         op.stall = $urandom_range(0, 3);
         op.dly   = $urandom_range(1, 3);
         op.hold  = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0) drain();
         run_op(op, r);
         compare($sformatf("rnd%0d", i), op, model(op), r);
      end

      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
